// File: rtl/reg_write_sched.sv
// Queues SPI register writes and commits them to the register file in bursts on engine update slots.
// Optional build macro REG_WRITE_SCHED_COALESCE_EN merges a write into a queued entry with the same address.
module reg_write_sched #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   spi_we_i,
  input  logic [ADDR_W-1:0]      spi_addr_i,
  input  logic [DATA_W-1:0]      spi_wdata_i,
  output logic [DATA_W-1:0]      spi_rdata_o,
  input  logic [DATA_W-1:0]      rf_rdata_i,
  output logic                   reg_we_o,
  output logic [ADDR_W-1:0]      reg_waddr_o,
  output logic [DATA_W-1:0]      reg_wdata_o,
  input  logic                   slot_i,
  input  logic                   flush_i,
  output logic [$clog2(DEPTH):0] pending_o,
  output logic                   drain_o,
  output logic                   overflow_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_mem_addr [DEPTH];
  logic [DATA_W-1:0] r_mem_data [DEPTH];
  logic [PW-1:0]     r_rd_ptr;
  logic [PW-1:0]     r_wr_ptr;
  logic [CW-1:0]     r_count;
  logic [CW-1:0]     r_burst;
  logic [CW-1:0]     w_burst_nxt;
  logic              r_ovf;
  logic              r_reg_we;
  logic [ADDR_W-1:0] r_reg_waddr;
  logic [DATA_W-1:0] r_reg_wdata;

  logic              w_pop;
  logic              w_full;
  logic              w_spi_ok;
  logic              w_push;
  logic              w_drop;
  logic              w_merge;
  logic              w_co_match;
  logic [PW-1:0]     w_co_idx;
  logic              w_fwd_hit;
  logic [DATA_W-1:0] w_fwd_data;

  assign w_full   = (r_count == CW'(DEPTH));
  assign w_spi_ok = spi_we_i && !flush_i;
  assign w_merge  = w_spi_ok && w_co_match;
  // A pop frees a slot in the same cycle, so a push to a full FIFO is still accepted.
  assign w_push   = w_spi_ok && !w_co_match && (!w_full || w_pop);
  assign w_drop   = w_spi_ok && !w_co_match && w_full && !w_pop;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // The first pop happens on the slot edge itself so writes land on cycles N+1..N+B;
  // r_burst counts the pops still owed after the current one.
  always_comb begin
    w_state_nxt = r_state;
    w_burst_nxt = r_burst;
    w_pop       = 1'b0;
    if (flush_i) begin
      w_state_nxt = IDLE;
      w_burst_nxt = '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (slot_i && (r_count != '0)) begin
            w_pop       = 1'b1;
            w_burst_nxt = r_count - CW'(1);
            w_state_nxt = DRAIN;
          end
        end
        DRAIN: begin
          if (r_burst != '0) begin
            w_pop       = 1'b1;
            w_burst_nxt = r_burst - CW'(1);
          end else begin
            w_state_nxt = IDLE;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

`ifdef REG_WRITE_SCHED_COALESCE_EN
  // The head being popped this cycle is leaving, so it is not a merge target.
  always_comb begin
    w_co_match = 1'b0;
    w_co_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((i < int'(r_count)) && !((i == 0) && w_pop) &&
          (r_mem_addr[r_rd_ptr + PW'(i)] == spi_addr_i)) begin
        w_co_match = 1'b1;
        w_co_idx   = r_rd_ptr + PW'(i);
      end
    end
  end
`else
  assign w_co_match = 1'b0;
  assign w_co_idx   = '0;
`endif

  // Scan oldest to newest so the newest matching entry wins.
  always_comb begin
    w_fwd_hit  = 1'b0;
    w_fwd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((i < int'(r_count)) && (r_mem_addr[r_rd_ptr + PW'(i)] == spi_addr_i)) begin
        w_fwd_hit  = 1'b1;
        w_fwd_data = r_mem_data[r_rd_ptr + PW'(i)];
      end
    end
  end

  assign spi_rdata_o = w_fwd_hit                                   ? w_fwd_data  :
                       (r_reg_we && (r_reg_waddr == spi_addr_i))   ? r_reg_wdata :
                                                                     rf_rdata_i;

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem_addr[r_wr_ptr] <= spi_addr_i;
      r_mem_data[r_wr_ptr] <= spi_wdata_i;
    end else if (w_merge) begin
      r_mem_data[w_co_idx] <= spi_wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_count     <= '0;
      r_burst     <= '0;
      r_ovf       <= 1'b0;
      r_reg_we    <= 1'b0;
      r_reg_waddr <= '0;
      r_reg_wdata <= '0;
    end else begin
      r_burst  <= w_burst_nxt;
      r_reg_we <= w_pop;
      if (w_pop) begin
        r_reg_waddr <= r_mem_addr[r_rd_ptr];
        r_reg_wdata <= r_mem_data[r_rd_ptr];
      end
      if (flush_i) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
        r_count  <= '0;
        r_ovf    <= 1'b0;
      end else begin
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + 1'b1;
        end
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + 1'b1;
        end
        if (w_push && !w_pop) begin
          r_count <= r_count + CW'(1);
        end else if (!w_push && w_pop) begin
          r_count <= r_count - CW'(1);
        end
        if (w_drop) begin
          r_ovf <= 1'b1;
        end
      end
    end
  end

  assign reg_we_o    = r_reg_we;
  assign reg_waddr_o = r_reg_waddr;
  assign reg_wdata_o = r_reg_wdata;
  assign pending_o   = r_count;
  assign drain_o     = (r_state == DRAIN);
  assign overflow_o  = r_ovf;

endmodule
